// File: rtl/bp_fe_ras_pkg.sv
// Return address stack shared definitions.
// Optional feature macro: BP_FE_RAS_REPAIR_EN (checkpoint carries the top entry
// so a restore can repair a top slot overwritten by a wrong-path call).

`ifdef BP_FE_RAS_REPAIR_EN
`define DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_mp, ras_els_mp) \
    typedef struct packed { \
        logic [vaddr_width_mp-1:0]          tgt; \
        logic [$clog2(ras_els_mp)-1:0]      ptr; \
        logic [$clog2(ras_els_mp+1)-1:0]    cnt; \
    } bp_fe_ras_ckpt_s
`else
`define DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_mp, ras_els_mp) \
    typedef struct packed { \
        logic [$clog2(ras_els_mp)-1:0]      ptr; \
        logic [$clog2(ras_els_mp+1)-1:0]    cnt; \
    } bp_fe_ras_ckpt_s
`endif

package bp_fe_ras_pkg;

    // Width of the checkpoint carried in branch metadata; must track the
    // field set of bp_fe_ras_ckpt_s.
    function automatic int bp_fe_ras_ckpt_width(int vaddr_width, int ras_els);
        int ptr_w;
        int cnt_w;
        ptr_w = $clog2(ras_els);
        cnt_w = $clog2(ras_els + 1);
`ifdef BP_FE_RAS_REPAIR_EN
        return vaddr_width + ptr_w + cnt_w;
`else
        return ptr_w + cnt_w;
`endif
    endfunction

endpackage

// File: rtl/bp_fe_ras.sv
// Multi-entry return address stack for the frontend PC generator.
// Pushes on fetched calls, predicts targets on fetched returns and exports a
// pre-update checkpoint that the backend hands back on redirect.
// Optional feature macro: BP_FE_RAS_REPAIR_EN (restore also rewrites the top entry).

module bp_fe_ras
    import bp_fe_ras_pkg::*;
#(
    parameter  int vaddr_width_p    = 39,
    parameter  int ras_els_p        = 8,
    localparam int ras_ptr_width_lp = $clog2(ras_els_p),
    localparam int ras_cnt_width_lp = $clog2(ras_els_p + 1),
    localparam int ckpt_width_lp    = bp_fe_ras_ckpt_width(vaddr_width_p, ras_els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     init_done_o,

    input  logic                     call_v_i,
    input  logic [vaddr_width_p-1:0] call_addr_i,
    input  logic                     ret_v_i,

    output logic [vaddr_width_p-1:0] tgt_o,
    output logic                     tgt_v_o,
    output logic [ckpt_width_lp-1:0] ckpt_o,

    input  logic                     restore_v_i,
    input  logic [ckpt_width_lp-1:0] restore_ckpt_i
);

    `DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_p, ras_els_p);

    localparam logic [ras_cnt_width_lp-1:0] cnt_full_lp = ras_cnt_width_lp'(ras_els_p);
    localparam logic [ras_ptr_width_lp-1:0] ptr_one_lp  = ras_ptr_width_lp'(1);

    logic [vaddr_width_p-1:0]    mem_r [ras_els_p];
    logic [ras_ptr_width_lp-1:0] ptr_r, ptr_n;
    logic [ras_cnt_width_lp-1:0] cnt_r, cnt_n;
    logic                        mem_we;
    logic [ras_ptr_width_lp-1:0] mem_waddr;
    logic [vaddr_width_p-1:0]    mem_wdata;
    logic                        init_done_r;
    bp_fe_ras_ckpt_s             ckpt_cur, ckpt_in;

    assign ckpt_in     = restore_ckpt_i;
    assign tgt_o       = mem_r[ptr_r];
    assign tgt_v_o     = (cnt_r != '0);
    assign ckpt_o      = ckpt_cur;
    assign init_done_o = init_done_r;

    // Snapshot of the registered state, i.e. before this cycle's update.
    always_comb begin
        ckpt_cur     = '0;
        ckpt_cur.ptr = ptr_r;
        ckpt_cur.cnt = cnt_r;
`ifdef BP_FE_RAS_REPAIR_EN
        ckpt_cur.tgt = mem_r[ptr_r];
`endif
    end

    // Next-state selection: restore beats call/ret; a simultaneous call and
    // ret replaces the top entry in place.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        ptr_n     = ptr_r;
        cnt_n     = cnt_r;
        mem_we    = 1'b0;
        mem_waddr = ptr_r;
        mem_wdata = call_addr_i;
        if (restore_v_i) begin
            ptr_n = ckpt_in.ptr;
            cnt_n = ckpt_in.cnt;
`ifdef BP_FE_RAS_REPAIR_EN
            mem_we    = 1'b1;
            mem_waddr = ckpt_in.ptr;
            mem_wdata = ckpt_in.tgt;
`endif
        end else if (call_v_i && ret_v_i) begin
            mem_we = 1'b1;
            cnt_n  = (cnt_r == '0) ? ras_cnt_width_lp'(1) : cnt_r;
        end else if (call_v_i) begin
            ptr_n     = ptr_r + ptr_one_lp;
            mem_we    = 1'b1;
            mem_waddr = ptr_r + ptr_one_lp;
            cnt_n     = (cnt_r == cnt_full_lp) ? cnt_r : cnt_r + ras_cnt_width_lp'(1);
        end else if (ret_v_i && (cnt_r != '0)) begin
            ptr_n = ptr_r - ptr_one_lp;
            cnt_n = cnt_r - ras_cnt_width_lp'(1);
        end
    end

    // Pointer, occupancy and init-done registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r       <= '0;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
        end else begin
            ptr_r       <= ptr_n;
            cnt_r       <= cnt_n;
            init_done_r <= 1'b1;
        end
    end

    // Flop-array storage; read combinationally through tgt_o.
    always_ff @(posedge clk_i) begin
        // NOTE: the stack array is cleared on reset so tgt_o and the
        // checkpoint read as zero afterwards, not stale addresses.
        if (reset_i) begin
            for (int i = 0; i < ras_els_p; i++) begin
                mem_r[i] <= '0;
            end
        end else if (mem_we) begin
            mem_r[mem_waddr] <= mem_wdata;
        end
    end

endmodule
